// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, owner tags and architectural widths.
package cpu_mem_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fixed-priority (data first) arbitration with a saturating counter that
// forces a fetch win after STARVE_MAX consecutive data wins over a pending fetch.
module arb_starve_ctr
    import cpu_mem_pkg::*;
#(
    parameter  int STARVE_MAX = 4,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic          d_req,
    input  logic          arb,
    output logic          win,
    output logic [SW-1:0] starve_cnt
);

    logic [SW-1:0] r_cnt;
    logic          w_starved;

    assign w_starved  = (r_cnt == SW'(STARVE_MAX));
    assign win        = (if_req && (!d_req || w_starved)) ? OWN_IF : OWN_D;
    assign starve_cnt = r_cnt;

    // Counter only moves on the strobe; it counts data wins that bypassed a waiting fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (arb) begin
            if (win == OWN_IF) begin
                r_cnt <= '0;
            end else if (if_req && !w_starved) begin
                r_cnt <= r_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency 64-bit memory port.
// One access in flight at a time: IDLE -> ISSUE -> (WAIT x MEM_LAT) -> RESP.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter  int MEM_LAT    = 2,
    parameter  int STARVE_MAX = 4,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [ILEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [1:0]      dbg_state,
    output logic [SW-1:0]   dbg_starve_cnt
);

    localparam int LW = $clog2(MEM_LAT + 1);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic            w_arb;
    logic            w_win;
    logic            w_lat_done;
    logic            r_owner;
    logic [LW-1:0]   r_lat_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [ILEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .d_req      (d_req),
        .arb        (w_arb),
        .win        (w_win),
        .starve_cnt (dbg_starve_cnt)
    );

    assign w_lat_done = (r_lat_cnt == LW'(MEM_LAT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Requests are looked at only in IDLE, so a request held through RESP is re-arbitrated as new.
    always_comb begin
        w_next = r_state;
        w_arb  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_arb  = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = r_mem_we ? ST_RESP : ST_WAIT;
            ST_WAIT:  w_next = w_lat_done ? ST_RESP : ST_WAIT;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_IF;
            r_lat_cnt   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_req <= w_arb;
            r_mem_we  <= w_arb && (w_win == OWN_D) && d_we;
            if (w_arb) begin
                r_owner    <= w_win;
                r_mem_addr <= (w_win == OWN_D) ? d_addr : if_addr;
                if (w_win == OWN_D) begin
                    r_mem_wdata <= d_wdata;
                end
            end
            case (r_state)
                ST_ISSUE: r_lat_cnt <= LW'(1);
                ST_WAIT: begin
                    if (w_lat_done) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_rdata[ILEN-1:0];
                        end else begin
                            r_d_rdata <= mem_rdata;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_valid  = (r_state == ST_RESP) && (r_owner == OWN_IF);
    assign d_valid   = (r_state == ST_RESP) && (r_owner == OWN_D);
    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance for most scenarios
// and a MEM_LAT=1 instance for back-to-back fetch spacing.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance 0: MEM_LAT = 2, STARVE_MAX = 4
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [63:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_starve_cnt;

    // Instance 1: MEM_LAT = 1
    logic        if_req1 = 0;
    logic [63:0] if_addr1 = 0, mem_rdata1;
    logic [31:0] if_rdata1;
    logic [63:0] d_rdata1, mem_addr1, mem_wdata1;
    logic        if_valid1, if_stall1, d_valid1, d_stall1, mem_req1, mem_we1;
    logic [1:0]  dbg_state1;
    logic [2:0]  dbg_starve_cnt1;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
        .if_valid(if_valid1), .if_stall(if_stall1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(64'h0), .d_wdata(64'h0),
        .d_rdata(d_rdata1), .d_valid(d_valid1), .d_stall(d_stall1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .dbg_state(dbg_state1), .dbg_starve_cnt(dbg_starve_cnt1)
    );

    // Memory model: stores commit in the strobe cycle; read data appears
    // exactly MEM_LAT cycles after the strobe, junk otherwise. Not reset.
    logic [63:0] mem [logic [63:0]];
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic logic [63:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {32'hC0DE_0000, a[31:0]};
    endfunction

    logic        q0_v = 0, q1_v = 0, p_v = 0;
    logic [63:0] q0_d = 0, q1_d = 0, p_d = 0;

    always @(posedge clk) begin
        if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
        q0_v <= mem_req && !mem_we;
        q0_d <= rd(mem_addr);
        q1_v <= q0_v;
        q1_d <= q0_d;
        p_v  <= mem_req1 && !mem_we1;
        p_d  <= rd(mem_addr1);
    end

    assign mem_rdata  = q1_v ? q1_d : JUNK;
    assign mem_rdata1 = p_v ? p_d : JUNK;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        n_vec++; if (mem_addr !== 64'h0) begin n_err++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        n_vec++; if ({if_valid, d_valid, if_stall, d_stall} !== 4'b0) begin n_err++; $display("FAIL reset_valids got=%0b exp=0", {if_valid, d_valid, if_stall, d_stall}); end
        n_vec++; if (if_rdata !== 32'h0 || d_rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", if_rdata, d_rdata); end
        n_vec++; if (dbg_state !== ST_IDLE || dbg_starve_cnt !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_starve_cnt); end
        n_vec++; if (mem_req1 !== 1'b0 || if_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_dut1 got=%0b%0b exp=00", mem_req1, if_valid1); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 64'h10;
        for (int c = 0; c <= 5; c++) begin
            #1;
            n_vec++; if (mem_req !== (c == 1)) begin n_err++; $display("FAIL fetch_mem_req c=%0d got=%0b exp=%0b", c, mem_req, c == 1); end
            n_vec++; if (if_valid !== (c == 4)) begin n_err++; $display("FAIL fetch_if_valid c=%0d got=%0b exp=%0b", c, if_valid, c == 4); end
            n_vec++; if (if_stall !== (c <= 3)) begin n_err++; $display("FAIL fetch_if_stall c=%0d got=%0b exp=%0b", c, if_stall, c <= 3); end
            if (c == 1) begin
                n_vec++; if (mem_we !== 1'b0 || mem_addr !== 64'h10) begin n_err++; $display("FAIL fetch_issue we/addr got=%0b/%0h exp=0/10", mem_we, mem_addr); end
            end
            if (c == 4) begin
                n_vec++; if (if_rdata !== 32'h00500293) begin n_err++; $display("FAIL fetch_rdata got=%0h exp=00500293", if_rdata); end
                if_req = 0;
            end
            tick();
        end
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 64'd17; d_wdata = 64'd42;
        for (int c = 0; c <= 4; c++) begin
            #1;
            n_vec++; if (mem_req !== (c == 1) || mem_we !== (c == 1)) begin n_err++; $display("FAIL store_req_we c=%0d got=%0b%0b exp=%0b%0b", c, mem_req, mem_we, c == 1, c == 1); end
            n_vec++; if (d_valid !== (c == 2)) begin n_err++; $display("FAIL store_d_valid c=%0d got=%0b exp=%0b", c, d_valid, c == 2); end
            n_vec++; if (dbg_state === ST_WAIT) begin n_err++; $display("FAIL store_no_wait c=%0d got=%0d exp=not 2", c, dbg_state); end
            n_vec++; if (d_stall !== (c < 2)) begin n_err++; $display("FAIL store_d_stall c=%0d got=%0b exp=%0b", c, d_stall, c < 2); end
            if (c == 1) begin
                n_vec++; if (mem_wdata !== 64'd42 || mem_addr !== 64'd17) begin n_err++; $display("FAIL store_issue got=%0d@%0d exp=42@17", mem_wdata, mem_addr); end
            end
            if (c == 2) begin d_req = 0; d_we = 0; end
            tick();
        end
    endtask

    task automatic test_dual();
        if_req = 1; if_addr = 64'h20;
        d_req = 1; d_we = 0; d_addr = 64'd17;
        for (int c = 0; c <= 10; c++) begin
            #1;
            n_vec++; if (mem_req !== (c == 1 || c == 6)) begin n_err++; $display("FAIL dual_mem_req c=%0d got=%0b exp=%0b", c, mem_req, c == 1 || c == 6); end
            n_vec++; if (d_valid !== (c == 4) || if_valid !== (c == 9)) begin n_err++; $display("FAIL dual_valids c=%0d got=%0b%0b exp=%0b%0b", c, d_valid, if_valid, c == 4, c == 9); end
            if (c == 1) begin
                n_vec++; if (mem_addr !== 64'd17) begin n_err++; $display("FAIL dual_d_addr got=%0h exp=11", mem_addr); end
            end
            if (c == 6) begin
                n_vec++; if (mem_addr !== 64'h20) begin n_err++; $display("FAIL dual_if_addr got=%0h exp=20", mem_addr); end
            end
            if (c == 4) begin
                n_vec++; if (d_rdata !== 64'd42) begin n_err++; $display("FAIL dual_d_rdata got=%0h exp=2a", d_rdata); end
                d_req = 0;
            end
            if (c == 9) begin
                n_vec++; if (if_rdata !== 32'h00A00313) begin n_err++; $display("FAIL dual_if_rdata got=%0h exp=00a00313", if_rdata); end
                if_req = 0;
            end
            tick();
        end
    endtask

    task automatic test_starve();
        int k = 0;
        bit done = 0;
        logic [63:0] exp_addr;
        logic [2:0]  exp_s;
        if_req = 1; if_addr = 64'h30;
        d_req = 1; d_we = 0; d_addr = 64'h40;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (mem_req) begin
                k++;
                exp_addr = (k <= 4) ? 64'h40 + 64'(k - 1) : 64'h30;
                exp_s    = (k <= 4) ? 3'(k) : 3'd0;
                n_vec++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL starve_winner arb=%0d got=%0h exp=%0h", k, mem_addr, exp_addr); end
                n_vec++; if (dbg_starve_cnt !== exp_s) begin n_err++; $display("FAIL starve_cnt arb=%0d got=%0d exp=%0d", k, dbg_starve_cnt, exp_s); end
            end
            if (d_valid) d_addr = d_addr + 64'd1;
            if (if_valid) begin
                if_req = 0; d_req = 0; done = 1;
            end
            tick();
        end
        n_vec++; if (!done || k != 5) begin n_err++; $display("FAIL starve_finish got=done%0d arbs%0d exp=done1 arbs5", done, k); end
        if_req = 0; d_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 64'h50;
        repeat (3) tick();
        #1;
        n_vec++; if (dbg_state !== ST_WAIT) begin n_err++; $display("FAIL rstmid_in_wait got=%0d exp=2", dbg_state); end
        reset = 1; d_req = 0;
        #1;
        n_vec++; if ({mem_req, mem_we, d_valid, if_valid, d_stall} !== 5'b0) begin n_err++; $display("FAIL rstmid_flags got=%0b exp=0", {mem_req, mem_we, d_valid, if_valid, d_stall}); end
        n_vec++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || d_rdata !== 64'h0 || if_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_data got=%0h/%0h/%0h/%0h exp=0", mem_addr, mem_wdata, d_rdata, if_rdata); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
        tick(); tick();
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_vec++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet c=%0d got=%0b%0b exp=00", c, d_valid, mem_req); end
            tick();
        end
        d_req = 1; d_addr = 64'h50;
        for (int c = 0; c <= 5; c++) begin
            #1;
            n_vec++; if (mem_req !== (c == 1) || d_valid !== (c == 4)) begin n_err++; $display("FAIL rstmid_restart c=%0d got=%0b%0b exp=%0b%0b", c, mem_req, d_valid, c == 1, c == 4); end
            if (c == 4) begin
                n_vec++; if (d_rdata !== 64'h1122334455667788) begin n_err++; $display("FAIL rstmid_rdata got=%0h exp=1122334455667788", d_rdata); end
                d_req = 0;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_ins [3];
        int last = 0, n_req = 0, n_valid = 0;
        exp_ins[0] = 32'h00100093; exp_ins[1] = 32'h00208113; exp_ins[2] = 32'h00310193;
        if_req1 = 1; if_addr1 = 64'h60;
        for (int cyc = 0; cyc < 60 && n_valid < 3; cyc++) begin
            #1;
            if (mem_req1) begin
                if (n_req > 0) begin
                    n_vec++; if (cyc - last != 4) begin n_err++; $display("FAIL b2b_spacing req=%0d got=%0d exp=4", n_req, cyc - last); end
                end
                last = cyc;
                n_req++;
            end
            if (if_valid1) begin
                n_vec++; if (if_rdata1 !== exp_ins[n_valid]) begin n_err++; $display("FAIL b2b_rdata n=%0d got=%0h exp=%0h", n_valid, if_rdata1, exp_ins[n_valid]); end
                n_valid++;
                if_addr1 = 64'h60 + 64'(n_valid);
                if (n_valid == 3) if_req1 = 0;
            end
            tick();
        end
        n_vec++; if (n_valid != 3 || n_req != 3) begin n_err++; $display("FAIL b2b_finish got=%0d/%0d exp=3/3", n_valid, n_req); end
        if_req1 = 0;
        tick();
    endtask

    initial begin
        mem[64'h10] = 64'h0000_0000_0050_0293;
        mem[64'h20] = 64'h0000_0000_00A0_0313;
        mem[64'h50] = 64'h1122_3344_5566_7788;
        mem[64'h60] = 64'h0000_0000_0010_0093;
        mem[64'h61] = 64'h0000_0000_0020_8113;
        mem[64'h62] = 64'h0000_0000_0031_0193;
        test_reset();
        test_fetch();
        test_store();
        test_dual();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency, word-addressed 64-bit memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Each requester holds a request until a one-cycle valid pulse returns its data; the arbiter serialises accesses, prioritises data accesses, and bounds fetch starvation. Its `if_stall` and `d_stall` outputs feed the pipeline's PC/IF-ID write enables and the MEM-stage freeze.

## Interface
- `MEM_LAT`, 2: cycles from the `mem_req` cycle to the cycle `mem_rdata` is valid; legal values ≥1.
- `STARVE_MAX`, 4: consecutive data wins tolerated while a fetch is pending; legal values ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 64: fetch word address.
- `if_rdata` out 32: instruction, `mem_rdata[31:0]`.
- `if_valid` out 1: one-cycle fetch completion pulse.
- `if_stall` out 1: `if_req & ~if_valid`, combinational.
- `d_req` in 1: data request; held until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 64: data word address.
- `d_wdata` in 64: store data.
- `d_rdata` out 64: load data.
- `d_valid` out 1: one-cycle data completion pulse.
- `d_stall` out 1: `d_req & ~d_valid`, combinational.
- `mem_req` out 1: one-cycle access strobe, registered.
- `mem_we` out 1: write enable, registered, qualified by `mem_req`.
- `mem_addr` out 64: access address, registered.
- `mem_wdata` out 64: write data, registered.
- `mem_rdata` in 64: read data, valid exactly `MEM_LAT` cycles after the `mem_req` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either request is high, arbitrate, latch owner/addr/we/wdata into the `mem_*` registers, go to ISSUE. Otherwise stay in IDLE.
- Arbitration rule: fetch wins if `if_req & (~d_req | starve_cnt == STARVE_MAX)`. Otherwise data wins.
- ISSUE: `mem_req` = 1 for exactly this cycle.
  - Store: go to RESP. The memory commits the write in the ISSUE cycle.
  - Load or fetch: go to WAIT, `lat_cnt` = 1.
- WAIT: hold for `MEM_LAT` cycles; `lat_cnt` increments each cycle. When `lat_cnt == MEM_LAT`, capture `mem_rdata` into the owner's rdata register and go to RESP.
- RESP: the owner's valid = 1 for this cycle only, then go to IDLE unconditionally.
  - A request seen in the following IDLE cycle is treated as new. A requester must update req/addr on the edge closing RESP.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Increments, saturating, when data wins while `if_req` = 1.
  - Clears when fetch wins.
  - Unchanged otherwise.
- `if_rdata` and `d_rdata` hold their last captured value until the next capture for that port.
- Request inputs are sampled only in IDLE. Changes during ISSUE, WAIT or RESP are ignored.
- Reset:
  - The FSM goes to IDLE.
  - All outputs, `starve_cnt` and `lat_cnt` go to 0.
  - Reset mid-operation abandons the in-flight access. A late `mem_rdata` is ignored and no valid pulse is generated.

## Timing
- Request first seen in IDLE cycle 0:
  - ISSUE is cycle 1.
  - Load/fetch: WAIT is cycles 2 to 1+MEM_LAT; `mem_rdata` is captured at the end of cycle 1+MEM_LAT; valid is in cycle 2+MEM_LAT.
  - Store: valid is in cycle 2.
- Throughput: one access per MEM_LAT+3 cycles for loads/fetches, per 3 cycles for stores.
- Only one access is ever outstanding; `mem_req` is never high in two consecutive cycles.
- `if_valid` and `d_valid` are never high in the same cycle.

## Structure
- Shared package `cpu_mem_pkg`:
  - State encoding (IDLE/ISSUE/WAIT/RESP).
  - Owner constants `OWN_IF`/`OWN_D`.
  - `XLEN` = 64 and `ILEN` = 32.
- One sub-module, `arb_starve_ctr`:
  - Inputs: `if_req`, `d_req`, arbitration strobe.
  - Outputs: winner and the saturating `starve_cnt`.
  - Parameter: `STARVE_MAX`.
- FSM, latency counter and response registers stay in `mem_port_arbiter`.

## Test plan
- Fetch only, MEM_LAT=2, `if_addr`=0x10, memory model returns 0x00500293 → `mem_req`=1, `mem_we`=0, `mem_addr`=0x10 in cycle 1; `if_valid`=1 with `if_rdata`=0x00500293 in cycle 4; `if_stall`=1 in cycles 0–3.
- Store `d_addr`=17, `d_wdata`=42 → `mem_req`=`mem_we`=1, `mem_wdata`=42 in cycle 1; `d_valid`=1 in cycle 2; no WAIT cycle.
- `if_req` and `d_req` (load) both rise in cycle 0 → data issued in cycle 1, `d_valid` in cycle 4; fetch issued in cycle 6, `if_valid` in cycle 9.
- STARVE_MAX=4, `d_req` held with a new load after every `d_valid`, `if_req` held → data wins arbitrations 1–4, fetch wins the 5th, `starve_cnt` then reads 0.
- Reset pulsed in the second WAIT cycle of a load → all outputs 0 immediately; no `d_valid` afterwards; the next request after release restarts at ISSUE.
- MEM_LAT=1, back-to-back fetches → `mem_req` pulses exactly 4 cycles apart; each `if_rdata` matches the `mem_rdata` presented one cycle after its `mem_req`.
